// File: rtl/ula_seq.sv
// Handshaked W-bit ALU: ADD/SUB/SHL/SHR/AND/OR/XOR/NOT with registered result and flags.
// Shifts are iterative, one bit per cycle, unless ULA_BARREL_EN is defined (single-cycle barrel).
module ula_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         c,
  output logic         v,
  output logic         zf,
  output logic         nf
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_SHIFT = 1'b1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_SHL = 3'd2;
  localparam logic [2:0] OP_SHR = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;

`ifdef ULA_BARREL_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  logic          state_q, state_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  s_q, s_d;
  logic          c_q, c_d, v_q, v_d, zf_q, zf_d, nf_q, nf_d;
  logic [W-1:0]  work_q, work_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          shl_q, shl_d;

  logic [W:0]    sum_w, diff_w, shl_w, shr_w;
  logic [W-1:0]  res;
  logic          res_c, res_v;
  logic          big_shift, is_shift, iter_start, accept;
  logic [W-1:0]  work_step;
  logic          step_c;
  logic          load;
  logic [W-1:0]  ld_s;
  logic          ld_c, ld_v;

  // Single-cycle result; the barrel shift also covers b == 0 in the iterative build
  always_comb begin
    sum_w     = {1'b0, a} + {1'b0, b};
    diff_w    = {1'b0, a} - {1'b0, b};
    shl_w     = {1'b0, a} << b;
    shr_w     = {a, 1'b0} >> b;
    big_shift = (32'(b) >= 32'(W));
    res       = '0;
    res_c     = 1'b0;
    res_v     = 1'b0;
    case (op)
      OP_ADD: begin
        res   = sum_w[W-1:0];
        res_c = sum_w[W];
        res_v = add_ovf(a[W-1], b[W-1], sum_w[W-1]);
      end
      OP_SUB: begin
        res   = diff_w[W-1:0];
        res_c = diff_w[W];
        res_v = sub_ovf(a[W-1], b[W-1], diff_w[W-1]);
      end
      OP_SHL: begin
        if (!big_shift) begin
          res   = shl_w[W-1:0];
          res_c = shl_w[W];
        end
      end
      OP_SHR: begin
        if (!big_shift) begin
          res   = shr_w[W:1];
          res_c = shr_w[0];
        end
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      default: res = ~a;
    endcase
  end

  assign is_shift   = (op == OP_SHL) || (op == OP_SHR);
  assign iter_start = !BARREL && is_shift && (b != '0) && !big_shift;
  assign in_ready   = (state_q == STATE_IDLE) && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;

  assign work_step = shl_q ? {work_q[W-2:0], 1'b0} : {1'b0, work_q[W-1:1]};
  assign step_c    = shl_q ? work_q[W-1] : work_q[0];

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    s_d         = s_q;
    c_d         = c_q;
    v_d         = v_q;
    zf_d        = zf_q;
    nf_d        = nf_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    shl_d       = shl_q;
    load        = 1'b0;
    ld_s        = res;
    ld_c        = res_c;
    ld_v        = res_v;

    if (out_valid_q && out_ready)
      out_valid_d = 1'b0;

    case (state_q)
      STATE_IDLE: begin
        if (accept) begin
          if (iter_start) begin
            work_d  = a;
            cnt_d   = b[CW-1:0];
            shl_d   = (op == OP_SHL);
            state_d = STATE_SHIFT;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: begin
        work_d = work_step;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          load    = 1'b1;
          ld_s    = work_step;
          ld_c    = step_c;
          ld_v    = 1'b0;
          state_d = STATE_IDLE;
        end
      end
    endcase

    // A new result wins over a same-edge drain
    if (load) begin
      s_d         = ld_s;
      c_d         = ld_c;
      v_d         = ld_v;
      zf_d        = (ld_s == '0);
      nf_d        = ld_s[W-1];
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= STATE_IDLE;
      out_valid_q <= 1'b0;
      s_q         <= '0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      zf_q        <= 1'b0;
      nf_q        <= 1'b0;
      work_q      <= '0;
      cnt_q       <= '0;
      shl_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
      c_q         <= c_d;
      v_q         <= v_d;
      zf_q        <= zf_d;
      nf_q        <= nf_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      shl_q       <= shl_d;
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign c         = c_q;
  assign v         = v_q;
  assign zf        = zf_q;
  assign nf        = nf_q;

endmodule

// File: tb/tb_ula_seq.sv
// Directed self-checking bench for ula_seq (W = 8); shift latency expectations follow ULA_BARREL_EN.
module tb_ula_seq;
  localparam int W = 8;
`ifdef ULA_BARREL_EN
  localparam bit BAR = 1'b1;
`else
  localparam bit BAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [2:0]   op;
  logic [W-1:0] a, b, s;
  logic         c, v, zf, nf;
  int           checks = 0;
  int           errors = 0;
  int           n, lows;

  always #5 clk = ~clk;

  ula_seq #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .c(c), .v(v), .zf(zf), .nf(nf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid, and samples with in_ready low
  task automatic wait_out(output int edges, output int low_cnt);
    edges = 0; low_cnt = 0;
    while (!out_valid && edges < 20) begin
      if (!in_ready) low_cnt++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", out_valid, 0);
    chk("rst_s", s, 0);
    chk("rst_flags", {c, v, zf, nf}, 4'b0000);
    chk("rst_rdy", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(3'd0, 8'h7F, 8'h01);
    chk("add1_ov", out_valid, 1);
    chk("add1_s", s, 8'h80);
    chk("add1_f", {c, v, zf, nf}, 4'b0101);
    issue(3'd0, 8'hFF, 8'h01);
    chk("add2_s", s, 8'h00);
    chk("add2_f", {c, v, zf, nf}, 4'b1010);
    issue(3'd1, 8'h03, 8'h05);
    chk("sub1_s", s, 8'hFE);
    chk("sub1_f", {c, v, zf, nf}, 4'b1001);
    issue(3'd1, 8'h80, 8'h01);
    chk("sub2_s", s, 8'h7F);
    chk("sub2_f", {c, v, zf, nf}, 4'b0100);

    issue(3'd2, 8'h81, 8'd3);
    wait_out(n, lows);
    chk("shl3_lat", n, BAR ? 0 : 3);
    chk("shl3_low", lows, BAR ? 0 : 3);
    chk("shl3_s", s, 8'h08);
    chk("shl3_f", {c, v, zf, nf}, 4'b0000);
    issue(3'd3, 8'h81, 8'd1);
    wait_out(n, lows);
    chk("shr1_lat", n, BAR ? 0 : 1);
    chk("shr1_s", s, 8'h40);
    chk("shr1_f", {c, v, zf, nf}, 4'b1000);
    issue(3'd3, 8'h81, 8'd8);
    wait_out(n, lows);
    chk("shr8_lat", n, 0);
    chk("shr8_s", s, 8'h00);
    chk("shr8_f", {c, v, zf, nf}, 4'b0010);
    issue(3'd2, 8'h81, 8'd0);
    wait_out(n, lows);
    chk("shl0_lat", n, 0);
    chk("shl0_s", s, 8'h81);
    chk("shl0_f", {c, v, zf, nf}, 4'b0001);

    // Backpressure: out_ready 0,0 then 1
    @(posedge clk); #1;
    chk("bp_drained", out_valid, 0);
    op = 3'd4; a = 8'hF0; b = 8'h3C; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    chk("bp_and_s", s, 8'h30);
    chk("bp_full_rdy", in_ready, 0);
    op = 3'd5; a = 8'hF0; b = 8'h0F;
    @(posedge clk); #1;
    chk("bp_stall1_s", s, 8'h30);
    chk("bp_stall1_ov", out_valid, 1);
    @(posedge clk); #1;
    chk("bp_stall2_s", s, 8'h30);
    out_ready = 1'b1;
    #1;
    chk("bp_rdy", in_ready, 1);
    @(posedge clk); #1;
    chk("bp_or_s", s, 8'hFF);
    chk("bp_or_f", {c, v, zf, nf}, 4'b0001);
    chk("bp_or_ov", out_valid, 1);
    op = 3'd6; a = 8'hFF; b = 8'h0F;
    @(posedge clk); #1;
    chk("bp_xor_s", s, 8'hF0);
    op = 3'd7; a = 8'h5A; b = 8'h00;
    @(posedge clk); #1;
    chk("bp_not_s", s, 8'hA5);
    chk("bp_not_f", {c, v, zf, nf}, 4'b0001);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_end_ov", out_valid, 0);
    chk("bp_hold_s", s, 8'hA5);

    // Reset in the middle of an iterative shift
    issue(3'd2, 8'h81, 8'd5);
    chk("mid_rdy", in_ready, BAR ? 1 : 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_s", s, 0);
    chk("mid_rst_f", {c, v, zf, nf}, 4'b0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("post_rst_ov", out_valid, 0);
    chk("post_rst_rdy", in_ready, 1);
    chk("post_rst_s", s, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
